// File: rtl/reset_sequencer.sv
// ==== reset_sequencer: holds all downstream stages in reset, then releases them in order ====
// Rev 1.0
`default_nettype none

module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGES      = 3,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rst_req,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic              done,
  output logic [7:0]        req_cnt
);

  localparam int c_MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CW    = $clog2(c_MAXHG) + 1;
  localparam int c_IW    = $clog2(STAGES + 1);

  localparam logic [c_CW-1:0]   c_HOLD_LAST = c_CW'(HOLD_CYCLES - 1);
  localparam logic [c_CW-1:0]   c_GAP_LAST  = c_CW'(GAP_CYCLES - 1);
  localparam logic [c_IW-1:0]   c_LAST_IDX  = c_IW'(STAGES - 1);
  localparam logic [STAGES-1:0] c_ONE       = STAGES'(1);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STAGGER = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [c_CW-1:0]   cnt_q, cnt_d;
  logic [c_IW-1:0]   idx_q, idx_d;
  logic [STAGES-1:0] rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [7:0]        req_cnt_q, req_cnt_d;
  logic              req_prev_q, req_prev_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    req_cnt_d  = req_cnt_q;
    req_prev_d = rst_req;

    if (rst_req && !req_prev_q && (req_cnt_q != 8'hFF)) begin
      req_cnt_d = req_cnt_q + 8'd1;
    end

    // A held request pins the block at the start of HOLD until it drops.
    if (rst_req) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == c_HOLD_LAST) begin
            rst_out_d = rst_out_q & ~c_ONE;
            cnt_d     = '0;
            idx_d     = c_IW'(1);
            if (STAGES == 1) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = S_STAGGER;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STAGGER: begin
          if (cnt_q == c_GAP_LAST) begin
            rst_out_d = rst_out_q & ~(c_ONE << idx_q);
            cnt_d     = '0;
            idx_d     = idx_q + c_IW'(1);
            if (idx_q == c_LAST_IDX) begin
              state_d = S_RUN;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        default: begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      req_cnt_q  <= 8'd0;
      req_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      req_cnt_q  <= req_cnt_d;
      req_prev_q <= req_prev_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign req_cnt = req_cnt_q;

endmodule

`default_nettype wire
